// File: rtl/counter_arbiter_pkg.sv
// Shared types and encodings for the counter arbiter and its interval counter.
package counter_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int   RESET_PTR = 0;
    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

endpackage

// File: rtl/counter_arbiter_interval_counter.sv
// Loadable up/down counter; at_terminal_o flags that the step taken on the
// coming edge lands on term_i, so the owner can leave RUN on that same edge.
module interval_counter
    import counter_arb_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] start_i,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic [WIDTH-1:0] term_i,
    output logic [WIDTH-1:0] count_o,
    output logic             at_terminal_o
);

    logic [WIDTH-1:0] count_q, count_d, step;

    assign step          = (dir_i == MODE_DOWN) ? count_q - 1'b1 : count_q + 1'b1;
    assign at_terminal_o = (step == term_i);
    assign count_o       = count_q;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = start_i;
        end else if (en_i) begin
            count_d = step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin scheduler that lends one interval counter to NREQ requesters.
// Handshake: req[i] is a level held until done[i] pulses or the requester aborts by dropping it.
module counter_arbiter
    import counter_arb_pkg::*;
#(
    parameter  int NREQ  = 2,
    parameter  int WIDTH = 5,
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] len,
    input  logic [NREQ-1:0]       mode,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic [WIDTH-1:0]      count,
    output logic                  cnt_mode,
    output logic [NREQ-1:0]       done,
    output state_e                dbg_state
);

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d, owner_q, owner_d, next_ptr, sel_idx, k_idx;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [WIDTH-1:0] len_q, len_d, ld_val, term;
    logic             cnt_mode_q, cnt_mode_d, sel_valid, ld, en, at_term;
    int               k;

    // First requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        k         = 0;
        k_idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(ptr_q) + i;
            if (k >= NREQ) k = k - NREQ;
            k_idx = PTR_W'(k);
            if (!sel_valid && req[k_idx]) begin
                sel_valid = 1'b1;
                sel_idx   = k_idx;
            end
        end
    end

    assign next_ptr = (owner_q == PTR_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    assign term     = (cnt_mode_q == MODE_DOWN) ? '0 : len_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        grant_d    = grant_q;
        len_d      = len_q;
        cnt_mode_d = cnt_mode_q;
        ld         = 1'b0;
        ld_val     = '0;
        en         = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    owner_d          = sel_idx;
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    len_d            = len[int'(sel_idx)*WIDTH +: WIDTH];
                    cnt_mode_d       = mode[sel_idx];
                    ld               = 1'b1;
                    ld_val           = (mode[sel_idx] == MODE_DOWN) ? len_d : '0;
                    state_d          = (len_d == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!req[owner_q]) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    cnt_mode_d = MODE_UP;
                    ptr_d      = next_ptr;
                end else begin
                    en = 1'b1;
                    if (at_term) state_d = DONE;
                end
            end
            DONE: begin
                state_d    = IDLE;
                grant_d    = '0;
                cnt_mode_d = MODE_UP;
                ptr_d      = next_ptr;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= PTR_W'(RESET_PTR);
            owner_q    <= '0;
            grant_q    <= '0;
            len_q      <= '0;
            cnt_mode_q <= MODE_UP;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            grant_q    <= grant_d;
            len_q      <= len_d;
            cnt_mode_q <= cnt_mode_d;
        end
    end

    interval_counter #(.WIDTH(WIDTH)) u_counter (
        .clk          (clk),
        .rst          (rst),
        .load_i       (ld),
        .start_i      (ld_val),
        .en_i         (en),
        .dir_i        (cnt_mode_q),
        .term_i       (term),
        .count_o      (count),
        .at_terminal_o(at_term)
    );

    assign grant     = grant_q;
    assign busy      = |grant_q;
    assign cnt_mode  = cnt_mode_q;
    assign done      = (state_q == DONE) ? grant_q : '0;
    assign dbg_state = state_q;

    a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_done_in_grant: assert property (@(posedge clk) disable iff (rst) (done & ~grant) == '0);
    a_busy_or:       assert property (@(posedge clk) disable iff (rst) busy == |grant);

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter with hand-computed expectations.
module tb_counter_arbiter;
    import counter_arb_pkg::*;

    localparam int NREQ  = 2;
    localparam int WIDTH = 5;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [WIDTH-1:0]      len0, len1;
    logic [NREQ*WIDTH-1:0] len;
    logic [NREQ-1:0]       mode;
    logic [NREQ-1:0]       grant, done;
    logic                  busy, cnt_mode;
    logic [WIDTH-1:0]      count;
    state_e                dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt;
    int exp_owner;

    assign len = {len1, len0};

    counter_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .len      (len),
        .mode     (mode),
        .grant    (grant),
        .busy     (busy),
        .count    (count),
        .cnt_mode (cnt_mode),
        .done     (done),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observe just after the edge so registered outputs have settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] g, input logic [4:0] c,
                              input logic [1:0] d);
        check({tag, " grant"}, 32'(grant), 32'(g));
        check({tag, " busy"},  32'(busy),  32'(|g));
        check({tag, " count"}, 32'(count), 32'(c));
        check({tag, " done"},  32'(done),  32'(d));
    endtask

    initial begin
        rst = 1'b1; req = '0; len0 = '0; len1 = '0; mode = '0;

        // Reset then idle
        tick(); tick();
        expect_out("reset", 2'b00, 5'd0, 2'b00);
        check("reset state", 32'(dbg_state), 32'(IDLE));
        check("reset cnt_mode", 32'(cnt_mode), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_out("idle", 2'b00, 5'd0, 2'b00);
        end

        // Single up request, len 5
        req = 2'b01; len0 = 5'd5; mode = 2'b00;
        tick();
        expect_out("up grant", 2'b01, 5'd0, 2'b00);
        check("up cnt_mode", 32'(cnt_mode), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            expect_out("up run", 2'b01, 5'(i), (i == 5) ? 2'b01 : 2'b00);
        end
        req = 2'b00;
        tick();
        expect_out("up release", 2'b00, 5'd5, 2'b00);

        // Down request len 3, then zero-length re-request
        req = 2'b10; len1 = 5'd3; mode = 2'b10;
        tick();
        expect_out("down grant", 2'b10, 5'd3, 2'b00);
        check("down cnt_mode", 32'(cnt_mode), 32'd1);
        for (int i = 2; i >= 0; i--) begin
            tick();
            expect_out("down run", 2'b10, 5'(i), (i == 0) ? 2'b10 : 2'b00);
        end
        tick();
        expect_out("down idle gap", 2'b00, 5'd0, 2'b00);
        len1 = 5'd0;
        tick();
        expect_out("zero len", 2'b10, 5'd0, 2'b10);
        req = 2'b00;
        tick();
        expect_out("zero len release", 2'b00, 5'd0, 2'b00);

        // Contention from reset: alternating 0,1,0,1
        rst = 1'b1;
        tick();
        rst = 1'b0; req = 2'b11; len0 = 5'd2; len1 = 5'd2; mode = 2'b00;
        exp_owner = 0;
        for (int g = 0; g < 4; g++) begin
            tick();
            expect_out("rr grant", 2'(1 << exp_owner), 5'd0, 2'b00);
            tick();
            expect_out("rr run", 2'(1 << exp_owner), 5'd1, 2'b00);
            tick();
            expect_out("rr done", 2'(1 << exp_owner), 5'd2, 2'(1 << exp_owner));
            tick();
            expect_out("rr idle", 2'b00, 5'd2, 2'b00);
            exp_owner = 1 - exp_owner;
        end
        req = 2'b00;

        // Abort on the 3rd RUN cycle of len 10
        req = 2'b01; len0 = 5'd10; mode = 2'b00;
        tick();
        expect_out("abort grant", 2'b01, 5'd0, 2'b00);
        tick();
        tick();
        expect_out("abort run3", 2'b01, 5'd2, 2'b00);
        req = 2'b00;
        tick();
        expect_out("abort", 2'b00, 5'd2, 2'b00);
        check("abort state", 32'(dbg_state), 32'(IDLE));
        tick();
        expect_out("abort frozen", 2'b00, 5'd2, 2'b00);

        // Reset mid-RUN; pointer must return to 0
        req = 2'b10; len1 = 5'd10; mode = 2'b10;
        tick();
        expect_out("rst grant", 2'b10, 5'd10, 2'b00);
        tick();
        expect_out("rst run", 2'b10, 5'd9, 2'b00);
        rst = 1'b1;
        tick();
        expect_out("mid reset", 2'b00, 5'd0, 2'b00);
        check("mid reset cnt_mode", 32'(cnt_mode), 32'd0);
        check("mid reset state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0; req = 2'b11;
        tick();
        expect_out("ptr after reset", 2'b01, 5'd0, 2'b00);
        req = 2'b00;
        tick();
        expect_out("ptr abort", 2'b00, 5'd0, 2'b00);

        // Maximum length 31
        req = 2'b01; len0 = 5'd31; mode = 2'b00;
        done_cnt = 0;
        tick();
        expect_out("max grant", 2'b01, 5'd0, 2'b00);
        for (int i = 1; i <= 31; i++) begin
            tick();
            if (done[0]) done_cnt++;
            expect_out("max run", 2'b01, 5'(i), (i == 31) ? 2'b01 : 2'b00);
        end
        req = 2'b00;
        tick();
        if (done[0]) done_cnt++;
        expect_out("max release", 2'b00, 5'd31, 2'b00);
        check("max done pulses", 32'(done_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
